conv_top_system: RTL and testbench
==================================

# conv_top_system

Convolution accelerator top level. It computes a KERNEL_SIZE×KERNEL_SIZE, INPUT_NB_CHANNELS→OUTPUT_NB_CHANNELS 2-D convolution over an ACTIVATIONS_WIDTH×ACTIVATIONS_HEIGHT feature map using one signed multiply-accumulate per cycle. The environment streams activation/weight operand pairs in a fixed loop order. The block emits one accumulated output pixel per output coordinate, tagged with x, y and channel.

## Interface
- IO_DATA_WIDTH, 16, operand width (a_input, b_input), signed two's complement
- ACCUMULATION_WIDTH, 38, accumulator/output width; must be ≥ 2·IO_DATA_WIDTH + clog2(KERNEL_SIZE²·INPUT_NB_CHANNELS)
- EXT_MEM_HEIGHT, 1<<20, external memory depth; interface compatibility only, no function
- EXT_MEM_WIDTH, 38, external memory width; interface compatibility only, no function
- ACTIVATIONS_WIDTH, 64, feature map width (x extent)
- ACTIVATIONS_HEIGHT, 64, feature map height (y extent)
- INPUT_NB_CHANNELS, 4, input channels
- OUTPUT_NB_CHANNELS, 32, output channels
- KERNEL_SIZE, 3, kernel side length
- clk  in  1  single clock, rising edge
- arst_n_in  in  1  asynchronous reset, active-high despite the name: asserted when 1
- a_input  in  IO_DATA_WIDTH  activation operand
- b_input  in  IO_DATA_WIDTH  weight operand
- a_valid / b_valid  in  1  operand valid
- a_ready / b_ready  out  1  operand ready
- out  out  ACCUMULATION_WIDTH  output pixel value
- output_valid  out  1  out and coordinates valid this cycle
- output_x  out  clog2(ACTIVATIONS_WIDTH)  output column
- output_y  out  clog2(ACTIVATIONS_HEIGHT)  output row
- output_ch  out  clog2(OUTPUT_NB_CHANNELS)  output channel
- start  in  1  begin one full-layer run
- running  out  1  run in progress

## Operation
- FSM states:
  - IDLE: start=1 → MAC; clear counters and accumulator; running=1.
  - MAC: a_ready = b_ready = 1.
  - OUT: one cycle; then the next pixel's MAC, or IDLE after the last pixel.
- Joint handshake in MAC: a transfer occurs only when a_valid & b_valid are both 1.
  - On a transfer: acc += signed(a_input)·signed(b_input), sign-extended to ACCUMULATION_WIDTH.
  - One valid without the other: no transfer, no state change.
- Operand order per output pixel: ky outer, kx, ci inner. That is K·K·CIN = 36 transfers per pixel with defaults.
- The environment supplies zero activations for padded (out-of-bounds) positions. The block does no padding logic.
- After the last transfer of a pixel → OUT: out = acc (final sum including the last product), output_valid=1, coordinates of that pixel. acc clears.
- Pixel order: y outer, x, ch inner. ch, then x, then y wrap at their maxima.
- After pixel (x=63, y=63, ch=31) → IDLE; running=0.
- start is ignored while running=1.
- Arithmetic is exact; the width rule above guarantees no overflow.

## Timing
- Reset (async, arst_n_in=1): state IDLE; all outputs 0 (out, output_valid, output_x/y/ch, running, a_ready, b_ready); counters and acc cleared.
- Reset mid-run aborts the run immediately. No output is produced for a partial pixel.
- running rises the cycle after start is sampled in IDLE and falls the cycle after the final OUT.
- output_valid is a single-cycle pulse, one cycle after the last operand transfer of a pixel. a_ready=b_ready=0 during OUT.
- Throughput: K·K·CIN+1 cycles per pixel with continuous valids.
- Critical path is one 16×16 multiply plus one 38-bit add, single cycle. All outputs are registered.

## Configuration
- OUTPUT_RELU_EN:
  - Defined: in OUT, a negative acc is emitted as 0 on out.
  - Undefined: out = acc unmodified (signed).
  - Only the value on out changes; handshakes and timing are identical either way.

## Test plan
- Reset: assert arst_n_in mid-MAC → all outputs 0 asynchronously. After release, running=0 until start.
- Single pixel: 36 pairs a=2, b=3 → out=216, output_valid 1 cycle, x=0, y=0, ch=0, one cycle after the 36th transfer.
- Signed/extremes: 36 pairs a=−32768, b=−32768 → out=38654705664. With a=−1, b=1 → out=−36 (0 when OUTPUT_RELU_EN is defined).
- Handshake: hold b_valid=0 with a_valid=1 for 5 cycles → no accumulate, no output. Random valid gaps → same result as the gap-free run.
- Ordering: after the first 32 pixels, the next output is x=1, y=0, ch=0. The last output is x=63, y=63, ch=31, then running=0. Total 131072 outputs.
- start pulsed while running → ignored; output count unchanged.

Source files
------------

// File: rtl/conv_top_system.sv
// rtl/conv_top_system.sv - streaming KxK conv accelerator top, one signed MAC per cycle
// Optional macro OUTPUT_RELU_EN clamps negative pixel sums to zero on out.
module conv_top_system #(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int ACCUMULATION_WIDTH = 38,
    parameter int EXT_MEM_HEIGHT     = 1 << 20,
    parameter int EXT_MEM_WIDTH      = 38,
    parameter int ACTIVATIONS_WIDTH  = 64,
    parameter int ACTIVATIONS_HEIGHT = 64,
    parameter int INPUT_NB_CHANNELS  = 4,
    parameter int OUTPUT_NB_CHANNELS = 32,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                                    clk,
    input  logic                                    arst_n_in,
    input  logic [IO_DATA_WIDTH-1:0]                a_input,
    input  logic                                    a_valid,
    output logic                                    a_ready,
    input  logic [IO_DATA_WIDTH-1:0]                b_input,
    input  logic                                    b_valid,
    output logic                                    b_ready,
    output logic [ACCUMULATION_WIDTH-1:0]           out,
    output logic                                    output_valid,
    output logic [$clog2(ACTIVATIONS_WIDTH)-1:0]    output_x,
    output logic [$clog2(ACTIVATIONS_HEIGHT)-1:0]   output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch,
    input  logic                                    start,
    output logic                                    running
);
    localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE * INPUT_NB_CHANNELS;
    localparam int CW   = $clog2(TAPS);
    localparam int XW   = $clog2(ACTIVATIONS_WIDTH);
    localparam int YW   = $clog2(ACTIVATIONS_HEIGHT);
    localparam int CHW  = $clog2(OUTPUT_NB_CHANNELS);
    localparam int PW   = 2 * IO_DATA_WIDTH;
    localparam int ACCW = ACCUMULATION_WIDTH;

    localparam logic [CW-1:0]  TAP_MAX = CW'(TAPS - 1);
    localparam logic [XW-1:0]  X_MAX   = XW'(ACTIVATIONS_WIDTH - 1);
    localparam logic [YW-1:0]  Y_MAX   = YW'(ACTIVATIONS_HEIGHT - 1);
    localparam logic [CHW-1:0] CH_MAX  = CHW'(OUTPUT_NB_CHANNELS - 1);

    // The external-memory parameters carry no function; they only take part in this sanity check.
    if (ACCW < PW + $clog2(TAPS) || EXT_MEM_WIDTH < 1 || EXT_MEM_HEIGHT < 1) begin : g_bad_cfg
        $error("conv_top_system: invalid parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_tap;
    logic [XW-1:0]           r_x, r_out_x;
    logic [YW-1:0]           r_y, r_out_y;
    logic [CHW-1:0]          r_ch, r_out_ch;
    logic signed [ACCW-1:0]  r_acc;
    logic [ACCW-1:0]         r_out;
    logic                    r_valid, r_ready, r_running;

    logic                    w_xfer, w_tap_last, w_pix_last;
    logic                    w_ready_nxt, w_running_nxt;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACCW-1:0]  w_sum;
    logic [ACCW-1:0]         w_result;

    assign w_xfer     = (r_state == S_MAC) && a_valid && b_valid;
    assign w_tap_last = (r_tap == TAP_MAX);
    assign w_pix_last = (r_ch == CH_MAX) && (r_x == X_MAX) && (r_y == Y_MAX);
    assign w_prod     = $signed(a_input) * $signed(b_input);
    assign w_sum      = r_acc + {{(ACCW - PW){w_prod[PW-1]}}, w_prod};

    always_ff @(posedge clk or posedge arst_n_in) begin
        if (arst_n_in) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_MAC;
            S_MAC:   if (w_xfer && w_tap_last) w_state_nxt = S_OUT;
            S_OUT:   w_state_nxt = w_pix_last ? S_IDLE : S_MAC;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake/status flops are loaded from the next state so they line up with r_state.
    always_comb begin
        w_ready_nxt   = (w_state_nxt == S_MAC);
        w_running_nxt = (w_state_nxt != S_IDLE);
        w_result      = w_sum;
`ifdef OUTPUT_RELU_EN
        if (w_sum[ACCW-1]) w_result = '0;
`endif
    end

    always_ff @(posedge clk or posedge arst_n_in) begin
        if (arst_n_in) begin
            r_ready   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_ready   <= w_ready_nxt;
            r_running <= w_running_nxt;
        end
    end

    always_ff @(posedge clk or posedge arst_n_in) begin
        if (arst_n_in) begin
            r_tap    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_ch     <= '0;
            r_acc    <= '0;
            r_out    <= '0;
            r_out_x  <= '0;
            r_out_y  <= '0;
            r_out_ch <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tap <= '0;
                        r_x   <= '0;
                        r_y   <= '0;
                        r_ch  <= '0;
                        r_acc <= '0;
                    end
                end
                S_MAC: begin
                    if (w_xfer) begin
                        if (w_tap_last) begin
                            r_acc    <= '0;
                            r_tap    <= '0;
                            r_out    <= w_result;
                            r_valid  <= 1'b1;
                            r_out_x  <= r_x;
                            r_out_y  <= r_y;
                            r_out_ch <= r_ch;
                        end else begin
                            r_acc <= w_sum;
                            r_tap <= r_tap + CW'(1);
                        end
                    end
                end
                S_OUT: begin
                    // Pixel order: ch fastest, then x, then y.
                    if (r_ch == CH_MAX) begin
                        r_ch <= '0;
                        if (r_x == X_MAX) begin
                            r_x <= '0;
                            r_y <= (r_y == Y_MAX) ? '0 : r_y + YW'(1);
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                    end else begin
                        r_ch <= r_ch + CHW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_ready      = r_ready;
    assign b_ready      = r_ready;
    assign running      = r_running;
    assign out          = r_out;
    assign output_valid = r_valid;
    assign output_x     = r_out_x;
    assign output_y     = r_out_y;
    assign output_ch    = r_out_ch;
endmodule

// File: tb/tb_conv_top_system.sv
// tb/tb_conv_top_system.sv - directed bench for conv_top_system on a reduced 4x2x4 output map
module tb_conv_top_system;
    localparam int IOW  = 16;
    localparam int ACCW = 38;
    localparam int AW   = 4;
    localparam int AH   = 2;
    localparam int CIN  = 4;
    localparam int COUT = 4;
    localparam int K    = 3;
    localparam int TAPS = K * K * CIN;
    localparam int NPIX = AW * AH * COUT;

    logic                     clk, rst, start, running;
    logic [IOW-1:0]           a_input, b_input;
    logic                     a_valid, b_valid, a_ready, b_ready;
    logic [ACCW-1:0]          out;
    logic                     output_valid;
    logic [$clog2(AW)-1:0]    output_x;
    logic [$clog2(AH)-1:0]    output_y;
    logic [$clog2(COUT)-1:0]  output_ch;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    int cyc      = 0;
    int c0, c1;

    conv_top_system #(
        .IO_DATA_WIDTH(IOW), .ACCUMULATION_WIDTH(ACCW), .EXT_MEM_HEIGHT(1 << 20), .EXT_MEM_WIDTH(38),
        .ACTIVATIONS_WIDTH(AW), .ACTIVATIONS_HEIGHT(AH), .INPUT_NB_CHANNELS(CIN),
        .OUTPUT_NB_CHANNELS(COUT), .KERNEL_SIZE(K)
    ) dut (
        .clk(clk), .arst_n_in(rst),
        .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready),
        .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready),
        .out(out), .output_valid(output_valid),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
        .start(start), .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int op_a(input int p, input int t);
        if (p == 0) return 2;
        if (p == 1) return -32768;
        if (p == 2) return -1;
        return p + 1 + 0 * t;
    endfunction

    function automatic int op_b(input int p, input int t);
        if (p == 0) return 3;
        if (p == 1) return -32768;
        if (p == 2) return 1;
        return t - 5;
    endfunction

    function automatic longint exp_val(input int p);
        longint s = 0;
        for (int t = 0; t < TAPS; t++) s += longint'(op_a(p, t)) * longint'(op_b(p, t));
`ifdef OUTPUT_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic send(input int a, input int b, input int gap);
        int w = 0;
        if (gap > 0) begin
            a_input = 16'h7fff;
            b_input = 16'h7fff;
            a_valid = gap[0];
            b_valid = !gap[0];
            repeat (gap) @(posedge clk);
            #1;
        end
        a_input = 16'(a);
        b_input = 16'(b);
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(negedge clk);
        while (!(a_ready && b_ready) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic send_pixel(input int p, input bit gaps);
        for (int t = 0; t < TAPS; t++)
            send(op_a(p, t), op_b(p, t), gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    always @(negedge clk) begin
        if (output_valid) begin
            if (n_out < NPIX) begin
                check("out_val", $signed(out), exp_val(n_out));
                check("out_ch", output_ch, n_out % COUT);
                check("out_x", output_x, (n_out / COUT) % AW);
                check("out_y", output_y, n_out / (COUT * AW));
            end else begin
                check("extra_output", n_out, NPIX - 1);
            end
            n_out++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog n_out %0d expected %0d", n_out, NPIX);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_input = '0; b_input = '0;
        #12;
        check("rst_out", out, 0);
        check("rst_valid", output_valid, 0);
        check("rst_xyc", {output_x, output_y, output_ch}, 0);
        check("rst_running", running, 0);
        check("rst_ready", {a_ready, b_ready}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("idle_running", running, 0);

        // Aborted partial run: reset mid-MAC must clear outputs without waiting for an edge.
        start = 1'b1;
        @(posedge clk); #1;
        check("run_rise", running, 1);
        start = 1'b0;
        for (int t = 0; t < 10; t++) send(op_a(0, t), op_b(0, t), 0);
        #2 rst = 1'b1;
        #1;
        check("async_running", running, 0);
        check("async_ready", {a_ready, b_ready}, 0);
        check("async_valid", output_valid, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_running", running, 0);
        check("post_rst_outs", n_out, 0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("run2_rise", running, 1);
        for (int p = 0; p < NPIX; p++) begin
            if (p == 3) begin
                a_input = 16'h7fff; b_input = 16'h7fff;
                a_valid = 1'b1; b_valid = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    check("hold_valid", output_valid, 0);
                    check("hold_ready", a_ready, 1);
                end
            end
            if (p == 6) start = 1'b1;
            send_pixel(p, (p >= 4) && (p % 2 == 0));
            start = 1'b0;
            if (p == 0) begin
                check("lat_valid", output_valid, 1);
                check("lat_ready", {a_ready, b_ready}, 0);
                c0 = cyc;
            end
            if (p == 1) begin
                c1 = cyc;
                check("throughput", c1 - c0, TAPS + 1);
            end
        end
        check("final_valid", output_valid, 1);
        check("final_running_hi", running, 1);
        @(posedge clk); #1;
        check("final_valid_pulse", output_valid, 0);
        check("final_running_lo", running, 0);
        check("final_ready", a_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        check("stay_idle", running, 0);
        check("out_count", n_out, NPIX);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
